// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - nibble-serial wide magnitude comparator driving an external 4-bit stage
// Optional feature macro: SMC_EARLY_EXIT_EN (finish on the first unequal slice)
module serial_magnitude_comparator #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [3:0]       cmp_a,
  output logic [3:0]       cmp_b,
  input  logic             cmp_agb,
  input  logic             cmp_aeb,
  input  logic             cmp_alb,
  output logic             busy,
  output logic             done,
  output logic             agb,
  output logic             aeb,
  output logic             alb,
  output logic             err
);

  localparam int N  = WIDTH / 4;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

`ifdef SMC_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] sh_a;
  logic [WIDTH-1:0] sh_b;
  logic [CW-1:0]    cnt;
  logic             decided;

  logic [2:0] trio;
  logic       trio_onehot;
  logic       first_unequal;
  logic       last_slice;

  // Slice decode: validity of the comparator answer and whether this slice settles the verdict
  always_comb begin
    trio          = {cmp_agb, cmp_aeb, cmp_alb};
    trio_onehot   = (trio == 3'b100) || (trio == 3'b010) || (trio == 3'b001);
    first_unequal = !cmp_aeb && !decided;
    last_slice    = (cnt == CW'(N - 1));
  end

  // Only RUN presents real slices; the comparator sees zeros otherwise
  always_comb begin
    cmp_a = 4'd0;
    cmp_b = 4'd0;
    if (state == RUN) begin
      cmp_a = sh_a[WIDTH-1 -: 4];
      cmp_b = sh_b[WIDTH-1 -: 4];
    end
  end

  // Control FSM with registered status and verdict outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sh_a    <= '0;
      sh_b    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
      agb     <= 1'b0;
      aeb     <= 1'b0;
      alb     <= 1'b0;
      err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            sh_a    <= a;
            sh_b    <= b;
            cnt     <= '0;
            decided <= 1'b0;
            agb     <= 1'b0;
            aeb     <= 1'b0;
            alb     <= 1'b0;
            err     <= 1'b0;
            busy    <= 1'b1;
            state   <= RUN;
          end
        end
        RUN: begin
          if (!trio_onehot) begin
            // A broken comparator answer voids the whole comparison
            err   <= 1'b1;
            agb   <= 1'b0;
            aeb   <= 1'b0;
            alb   <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            sh_a <= sh_a << 4;
            sh_b <= sh_b << 4;
            cnt  <= cnt + CW'(1);
            if (first_unequal) begin
              agb     <= cmp_agb;
              alb     <= cmp_alb;
              decided <= 1'b1;
            end
            if (last_slice && !decided && !first_unequal) begin
              aeb <= 1'b1;
            end
            if (last_slice || (EARLY_EXIT && first_unequal)) begin
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          // start is deliberately not looked at here
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
